// File: rtl/fu_writeback_arbiter.sv
// Writeback arbiter: per-source result FIFOs drained round-robin onto a single
// register-file writeback / wakeup port, with grant hold under backpressure.
module fu_writeback_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_full,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [TAG_W-1:0]            wb_tag,
  output logic [DATA_W-1:0]           wb_data,
  output logic [$clog2(NUM_SRC)-1:0]  wb_src,
  output logic                        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int ENT_W = TAG_W + DATA_W;
  localparam int unsigned NS = NUM_SRC;

  logic [ENT_W-1:0] mem [NUM_SRC][DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr [NUM_SRC];
  logic [CNT_W-1:0] count  [NUM_SRC];

  logic [SRC_W-1:0] rr_ptr, lock_idx, scan_idx, grant;
  logic             lock, scan_found, hs;
  logic [NUM_SRC-1:0] nonempty, push, pop, drop, accept;
  logic [ENT_W-1:0] head;

  always_comb begin
    for (int unsigned i = 0; i < NS; i++) begin
      nonempty[i] = (count[i] != '0);
      src_full[i] = (count[i] >= CNT_W'(DEPTH - 1));
    end
  end

  // First non-empty FIFO starting from rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    int unsigned c;
    c          = 0;
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int unsigned k = 0; k < NS; k++) begin
      c = (32'(rr_ptr) + k) % NS;
      if (!scan_found && nonempty[c]) begin
        scan_found = 1'b1;
        scan_idx   = SRC_W'(c);
      end
    end
  end

  always_comb begin
    grant    = lock ? lock_idx : scan_idx;
    wb_valid = |nonempty;
    head     = mem[grant][rd_ptr[grant]];
    wb_tag   = wb_valid ? head[ENT_W-1:DATA_W] : '0;
    wb_data  = wb_valid ? head[DATA_W-1:0] : '0;
    wb_src   = wb_valid ? grant : '0;
    hs       = wb_valid & wb_ready;
  end

  // A full FIFO still accepts a push when it is popped in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < NS; i++) begin
      push[i]   = src_valid[i] & ~flush;
      pop[i]    = hs & ~flush & (grant == SRC_W'(i));
      drop[i]   = push[i] & (count[i] == CNT_W'(DEPTH)) & ~pop[i];
      accept[i] = push[i] & ~drop[i];
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NS; i++) begin
      if (accept[i]) mem[i][wr_ptr[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      lock <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NS; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CNT_W'(accept[i]) - CNT_W'(pop[i]);
      end
      if (|drop) overflow <= 1'b1;
      if (hs) begin
        rr_ptr <= (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
        lock   <= 1'b0;
      end else if (wb_valid) begin
        lock     <= 1'b1;
        lock_idx <= grant;
      end
    end
  end

endmodule
